// File: rtl/id_decode_if.sv
// id_decode_if: groups the decode-stage bus signals.
//   Fetch side  : id_valid/id_ready handshake, id_pc, id_instr.
//   Regfile side: rs1_addr/rs2_addr out, rs1_data/rs2_data in (same cycle).
//   Control     : flush.
//   Execute side: ex_valid/ex_ready handshake plus the decoded bundle.
// Handshake semantics (both sides): a transfer happens on a rising clock
// edge where valid && ready are both 1; a producer holding valid=1 keeps its
// payload stable until that transfer, and valid never depends on ready.
// modport slave  : the decode stage itself.
// modport master : the surrounding pipeline (fetch, regfile, execute).
interface id_decode_if;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [3:0]  ex_op;
  logic        ex_br_inv;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs2_data;
  logic [4:0]  ex_rd;
  logic        ex_rd_we;
  logic        ex_is_load;
  logic        ex_is_store;
  logic        ex_is_branch;
  logic        ex_is_jal;
  logic        ex_is_jalr;
  logic        ex_illegal;

  modport slave (
    input  id_valid, id_pc, id_instr, rs1_data, rs2_data, flush, ex_ready,
    output id_ready, rs1_addr, rs2_addr, ex_valid, ex_a, ex_b, ex_op,
           ex_br_inv, ex_pc, ex_imm, ex_rs2_data, ex_rd, ex_rd_we,
           ex_is_load, ex_is_store, ex_is_branch, ex_is_jal, ex_is_jalr,
           ex_illegal
  );

  modport master (
    output id_valid, id_pc, id_instr, rs1_data, rs2_data, flush, ex_ready,
    input  id_ready, rs1_addr, rs2_addr, ex_valid, ex_a, ex_b, ex_op,
           ex_br_inv, ex_pc, ex_imm, ex_rs2_data, ex_rd, ex_rd_we,
           ex_is_load, ex_is_store, ex_is_branch, ex_is_jal, ex_is_jalr,
           ex_illegal
  );
endinterface

// File: rtl/id_decode.sv
// id_decode: RV32I decode stage with a single registered output bundle.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears the output bundle
//   bus   : id_decode_if.slave (fetch handshake, regfile ports, flush,
//           execute handshake and decoded bundle)
// Detects load-use hazards against the bundle in the output register and
// inserts one bubble; flush kills the output bundle synchronously.
module id_decode (
  input  logic           clk,
  input  logic           rst_n,
  id_decode_if.slave     bus
);
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2,
                         OP_AND = 4'd3, OP_OR  = 4'd4, OP_XOR = 4'd5,
                         OP_SHL = 4'd6, OP_SHR = 4'd7, OP_SLT = 4'd8,
                         OP_BEQ = 4'd11, OP_BLT = 4'd13;

  localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111,
                         OPC_JAL = 7'b1101111, OPC_JALR  = 7'b1100111,
                         OPC_BR  = 7'b1100011, OPC_LOAD  = 7'b0000011,
                         OPC_ST  = 7'b0100011, OPC_OPIMM = 7'b0010011,
                         OPC_OP  = 7'b0110011;

  logic [31:0] instr;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt_i, shamt_r;

  assign instr   = bus.id_instr;
  assign opcode  = instr[6:0];
  assign rd      = instr[11:7];
  assign funct3  = instr[14:12];
  assign funct7  = instr[31:25];
  assign imm_i   = {{20{instr[31]}}, instr[31:20]};
  assign imm_s   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u   = {instr[31:12], 12'b0};
  assign imm_j   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign shamt_i = {27'b0, instr[24:20]};
  assign shamt_r = {27'b0, bus.rs2_data[4:0]};

  assign bus.rs1_addr = instr[19:15];
  assign bus.rs2_addr = instr[24:20];

  // Decoded bundle (combinational)
  logic [31:0] d_a, d_b, d_imm;
  logic [3:0]  d_op;
  logic        d_br_inv, d_wb, d_bias, d_illegal;
  logic        d_load, d_store, d_branch, d_jal, d_jalr;
  logic        use_rs1, use_rs2;
  logic [31:0] f_a, f_b;
  logic [3:0]  f_op;
  logic        f_br_inv, f_rd_we;

  always_comb begin
    d_a = bus.rs1_data;  d_b = bus.rs2_data;  d_imm = 32'b0;
    d_op = OP_ADD;  d_br_inv = 1'b0;  d_wb = 1'b0;  d_bias = 1'b0;
    d_illegal = 1'b0;  d_load = 1'b0;  d_store = 1'b0;  d_branch = 1'b0;
    d_jal = 1'b0;  d_jalr = 1'b0;  use_rs1 = 1'b0;  use_rs2 = 1'b0;
    case (opcode)
      OPC_OP: begin
        use_rs1 = 1'b1;  use_rs2 = 1'b1;  d_wb = 1'b1;
        case (funct7)
          7'b0000000: begin
            case (funct3)
              3'b000: d_op = OP_ADD;
              3'b001: begin d_op = OP_SHL; d_b = shamt_r; end
              3'b010: begin d_op = OP_SLT; d_bias = 1'b1; end
              3'b011: d_op = OP_SLT;
              3'b100: d_op = OP_XOR;
              3'b101: begin d_op = OP_SHR; d_b = shamt_r; end
              3'b110: d_op = OP_OR;
              default: d_op = OP_AND;
            endcase
          end
          7'b0100000: if (funct3 == 3'b000) d_op = OP_SUB; else d_illegal = 1'b1;
          7'b0000001: if (funct3 == 3'b000) d_op = OP_MUL; else d_illegal = 1'b1;
          default:    d_illegal = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        use_rs1 = 1'b1;  d_wb = 1'b1;  d_imm = imm_i;  d_b = imm_i;
        case (funct3)
          3'b000: d_op = OP_ADD;
          3'b001: begin d_op = OP_SHL; d_b = shamt_i; end
          3'b010: begin d_op = OP_SLT; d_bias = 1'b1; end
          3'b011: d_op = OP_SLT;
          3'b100: d_op = OP_XOR;
          // instr[30] distinguishes SRAI, which the ALU cannot execute
          3'b101: if (instr[30]) d_illegal = 1'b1;
                  else begin d_op = OP_SHR; d_b = shamt_i; end
          3'b110: d_op = OP_OR;
          default: d_op = OP_AND;
        endcase
      end
      OPC_LOAD: begin
        use_rs1 = 1'b1;  d_wb = 1'b1;  d_load = 1'b1;  d_imm = imm_i;  d_b = imm_i;
      end
      OPC_ST: begin
        use_rs1 = 1'b1;  use_rs2 = 1'b1;  d_store = 1'b1;  d_imm = imm_s;  d_b = imm_s;
      end
      OPC_BR: begin
        use_rs1 = 1'b1;  use_rs2 = 1'b1;  d_branch = 1'b1;  d_imm = imm_b;
        case (funct3)
          3'b000: d_op = OP_BEQ;
          3'b001: begin d_op = OP_BEQ; d_br_inv = 1'b1; end
          3'b100: begin d_op = OP_BLT; d_bias = 1'b1; end
          3'b101: begin d_op = OP_BLT; d_bias = 1'b1; d_br_inv = 1'b1; end
          3'b110: d_op = OP_BLT;
          3'b111: begin d_op = OP_BLT; d_br_inv = 1'b1; end
          default: d_illegal = 1'b1;
        endcase
      end
      OPC_LUI:   begin d_a = 32'b0;     d_b = imm_u;  d_imm = imm_u; d_wb = 1'b1; end
      OPC_AUIPC: begin d_a = bus.id_pc; d_b = imm_u;  d_imm = imm_u; d_wb = 1'b1; end
      // Link value pc+4 comes out of the ALU
      OPC_JAL:   begin d_a = bus.id_pc; d_b = 32'd4;  d_imm = imm_j; d_wb = 1'b1; d_jal = 1'b1; end
      OPC_JALR:  begin
        use_rs1 = 1'b1;  d_a = bus.id_pc;  d_b = 32'd4;  d_imm = imm_i;  d_wb = 1'b1;  d_jalr = 1'b1;
      end
      default: d_illegal = 1'b1;
    endcase
  end

  // Final bundle: illegal instructions issue as a harmless ADD without side
  // effects; signed compares are turned into unsigned by flipping bit 31.
  always_comb begin
    f_a = d_a;  f_b = d_b;  f_op = d_op;  f_br_inv = d_br_inv;
    f_rd_we = d_wb && (rd != 5'd0);
    if (d_illegal) begin
      f_op = OP_ADD;  f_br_inv = 1'b0;  f_rd_we = 1'b0;
    end else if (d_bias) begin
      f_a = {~d_a[31], d_a[30:0]};
      f_b = {~d_b[31], d_b[30:0]};
    end
  end

  // Output register
  logic        ex_valid_q;
  logic [31:0] ex_a_q, ex_b_q, ex_pc_q, ex_imm_q, ex_rs2_q;
  logic [3:0]  ex_op_q;
  logic [4:0]  ex_rd_q;
  logic        ex_br_inv_q, ex_rd_we_q, ex_load_q, ex_store_q, ex_branch_q;
  logic        ex_jal_q, ex_jalr_q, ex_illegal_q;
  logic        stall, accept;

  assign stall = ex_valid_q && ex_load_q && (ex_rd_q != 5'd0) && bus.id_valid &&
                 ((use_rs1 && bus.rs1_addr == ex_rd_q) || (use_rs2 && bus.rs2_addr == ex_rd_q));
  assign bus.id_ready = (!ex_valid_q || bus.ex_ready) && !stall && !bus.flush;
  assign accept = bus.id_valid && bus.id_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;  ex_a_q <= '0;  ex_b_q <= '0;  ex_pc_q <= '0;
      ex_imm_q <= '0;  ex_rs2_q <= '0;  ex_op_q <= '0;  ex_rd_q <= '0;
      ex_br_inv_q <= 1'b0;  ex_rd_we_q <= 1'b0;  ex_load_q <= 1'b0;
      ex_store_q <= 1'b0;  ex_branch_q <= 1'b0;  ex_jal_q <= 1'b0;
      ex_jalr_q <= 1'b0;  ex_illegal_q <= 1'b0;
    end else if (bus.flush) begin
      ex_valid_q <= 1'b0;
    end else if (accept) begin
      ex_valid_q   <= 1'b1;
      ex_a_q       <= f_a;
      ex_b_q       <= f_b;
      ex_pc_q      <= bus.id_pc;
      ex_imm_q     <= d_imm;
      ex_rs2_q     <= bus.rs2_data;
      ex_op_q      <= f_op;
      ex_rd_q      <= rd;
      ex_br_inv_q  <= f_br_inv;
      ex_rd_we_q   <= f_rd_we;
      ex_load_q    <= d_load   && !d_illegal;
      ex_store_q   <= d_store  && !d_illegal;
      ex_branch_q  <= d_branch && !d_illegal;
      ex_jal_q     <= d_jal    && !d_illegal;
      ex_jalr_q    <= d_jalr   && !d_illegal;
      ex_illegal_q <= d_illegal;
    end else if (bus.ex_ready) begin
      // Also produces the load-use bubble while stalled
      ex_valid_q <= 1'b0;
    end
  end

  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_a         = ex_a_q;
  assign bus.ex_b         = ex_b_q;
  assign bus.ex_op        = ex_op_q;
  assign bus.ex_br_inv    = ex_br_inv_q;
  assign bus.ex_pc        = ex_pc_q;
  assign bus.ex_imm       = ex_imm_q;
  assign bus.ex_rs2_data  = ex_rs2_q;
  assign bus.ex_rd        = ex_rd_q;
  assign bus.ex_rd_we     = ex_rd_we_q;
  assign bus.ex_is_load   = ex_load_q;
  assign bus.ex_is_store  = ex_store_q;
  assign bus.ex_is_branch = ex_branch_q;
  assign bus.ex_is_jal    = ex_jal_q;
  assign bus.ex_is_jalr   = ex_jalr_q;
  assign bus.ex_illegal   = ex_illegal_q;
endmodule

// File: tb/tb_id_decode.sv
// tb_id_decode: directed bench for id_decode with hand-computed expectations.
module tb_id_decode;
  logic clk;
  logic rst_n;
  id_decode_if bus ();

  id_decode dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b);
    bus.id_valid = 1'b1;
    bus.id_instr = instr;
    bus.id_pc    = pc;
    bus.rs1_data = a;
    bus.rs2_data = b;
  endtask

  task automatic idle();
    bus.id_valid = 1'b0;
    bus.id_instr = 32'h0000_0013;
  endtask

  // Issue one instruction with ex_ready=1 and score its operand A
  task automatic issue(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_a);
    drive(instr, pc, a, b);
    exp_q.push_back(exp_a);
    step();
    check({tag, ".valid"}, {31'b0, bus.ex_valid}, 32'd1);
    check({tag, ".a"}, bus.ex_a, exp_q.pop_front());
  endtask

  initial begin
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.ex_ready = 1'b1;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    bus.id_pc = '0;
    idle();
    #1;
    check("rst.valid", {31'b0, bus.ex_valid}, 32'd0);
    check("rst.a", bus.ex_a, 32'd0);
    check("rst.op", {28'b0, bus.ex_op}, 32'd0);
    check("rst.id_ready", {31'b0, bus.id_ready}, 32'd1);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // ADD x3,x1,x2
    drive(32'h002081B3, 32'h0000_0010, 32'd5, 32'd7);
    #1;
    check("add.rs1_addr", {27'b0, bus.rs1_addr}, 32'd1);
    check("add.rs2_addr", {27'b0, bus.rs2_addr}, 32'd2);
    check("add.id_ready", {31'b0, bus.id_ready}, 32'd1);
    step();
    idle();
    check("add.valid", {31'b0, bus.ex_valid}, 32'd1);
    check("add.op", {28'b0, bus.ex_op}, 32'd0);
    check("add.a", bus.ex_a, 32'd5);
    check("add.b", bus.ex_b, 32'd7);
    check("add.rd", {27'b0, bus.ex_rd}, 32'd3);
    check("add.rd_we", {31'b0, bus.ex_rd_we}, 32'd1);
    check("add.pc", bus.ex_pc, 32'h10);

    // BGE x1,x2,+8 with signed bias
    drive(32'h0020D463, 32'h0000_0040, 32'hFFFF_FFFF, 32'd1);
    step();
    idle();
    check("bge.op", {28'b0, bus.ex_op}, 32'd13);
    check("bge.br_inv", {31'b0, bus.ex_br_inv}, 32'd1);
    check("bge.a", bus.ex_a, 32'h7FFF_FFFF);
    check("bge.b", bus.ex_b, 32'h8000_0001);
    check("bge.imm", bus.ex_imm, 32'd8);
    check("bge.is_branch", {31'b0, bus.ex_is_branch}, 32'd1);
    check("bge.rd_we", {31'b0, bus.ex_rd_we}, 32'd0);
    check("bge.rs2_data", bus.ex_rs2_data, 32'd1);
    step();
    check("drain.valid", {31'b0, bus.ex_valid}, 32'd0);

    // Load-use: lw x5,0(x1) then add x6,x5,x1
    drive(32'h0000A283, 32'h0000_0080, 32'h100, 32'd0);
    step();
    drive(32'h00128333, 32'h0000_0084, 32'd9, 32'h100);
    #1;
    check("lu.stall_ready", {31'b0, bus.id_ready}, 32'd0);
    check("lu.is_load", {31'b0, bus.ex_is_load}, 32'd1);
    check("lu.load_a", bus.ex_a, 32'h100);
    check("lu.load_rd", {27'b0, bus.ex_rd}, 32'd5);
    step();
    check("lu.bubble", {31'b0, bus.ex_valid}, 32'd0);
    check("lu.ready_after", {31'b0, bus.id_ready}, 32'd1);
    step();
    check("lu.add_valid", {31'b0, bus.ex_valid}, 32'd1);
    check("lu.add_a", bus.ex_a, 32'd9);
    check("lu.add_b", bus.ex_b, 32'h100);
    check("lu.add_rd", {27'b0, bus.ex_rd}, 32'd6);

    // Backpressure: sub x7,x1,x2 waits behind the held add
    bus.ex_ready = 1'b0;
    drive(32'h402083B3, 32'h0000_0088, 32'd20, 32'd3);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp.id_ready", {31'b0, bus.id_ready}, 32'd0);
      check("bp.hold_a", bus.ex_a, 32'd9);
      check("bp.hold_rd", {27'b0, bus.ex_rd}, 32'd6);
      check("bp.hold_valid", {31'b0, bus.ex_valid}, 32'd1);
      step();
    end
    bus.ex_ready = 1'b1;
    #1;
    check("bp.release_ready", {31'b0, bus.id_ready}, 32'd1);
    step();
    idle();
    check("bp.sub_op", {28'b0, bus.ex_op}, 32'd1);
    check("bp.sub_a", bus.ex_a, 32'd20);
    check("bp.sub_b", bus.ex_b, 32'd3);
    check("bp.sub_rd", {27'b0, bus.ex_rd}, 32'd7);

    // Back-to-back stream
    issue("xor", 32'h0020C433, 32'h100, 32'd5, 32'd3, 32'd5);
    check("xor.op", {28'b0, bus.ex_op}, 32'd5);
    issue("slt", 32'h0020A4B3, 32'h104, 32'd5, 32'd3, 32'h8000_0005);
    check("slt.op", {28'b0, bus.ex_op}, 32'd8);
    check("slt.b", bus.ex_b, 32'h8000_0003);
    issue("sltu", 32'h0020B4B3, 32'h108, 32'd5, 32'd3, 32'd5);
    check("sltu.b", bus.ex_b, 32'd3);
    issue("addi", 32'hFFF08513, 32'h10C, 32'd5, 32'd3, 32'd5);
    check("addi.b", bus.ex_b, 32'hFFFF_FFFF);
    check("addi.imm", bus.ex_imm, 32'hFFFF_FFFF);
    check("addi.rd", {27'b0, bus.ex_rd}, 32'd10);
    issue("lui", 32'h123455B7, 32'h110, 32'd5, 32'd3, 32'd0);
    check("lui.b", bus.ex_b, 32'h1234_5000);
    issue("jal", 32'h010000EF, 32'h200, 32'd5, 32'd3, 32'h200);
    check("jal.b", bus.ex_b, 32'd4);
    check("jal.imm", bus.ex_imm, 32'd16);
    check("jal.is_jal", {31'b0, bus.ex_is_jal}, 32'd1);
    check("jal.rd_we", {31'b0, bus.ex_rd_we}, 32'd1);

    // Flush with a valid bundle and a valid input
    drive(32'h402083B3, 32'h0000_0300, 32'd1, 32'd1);
    bus.flush = 1'b1;
    #1;
    check("flush.id_ready", {31'b0, bus.id_ready}, 32'd0);
    step();
    bus.flush = 1'b0;
    idle();
    check("flush.valid", {31'b0, bus.ex_valid}, 32'd0);
    check("flush.not_loaded", {27'b0, bus.ex_rd}, 32'd1);

    // Illegal: SRA and branch funct3=010
    drive(32'h4020D1B3, 32'h0000_0310, 32'd4, 32'd1);
    step();
    idle();
    check("sra.valid", {31'b0, bus.ex_valid}, 32'd1);
    check("sra.illegal", {31'b0, bus.ex_illegal}, 32'd1);
    check("sra.rd_we", {31'b0, bus.ex_rd_we}, 32'd0);
    check("sra.op", {28'b0, bus.ex_op}, 32'd0);
    drive(32'h0020A063, 32'h0000_0320, 32'h55, 32'd1);
    step();
    idle();
    check("badbr.illegal", {31'b0, bus.ex_illegal}, 32'd1);
    check("badbr.is_branch", {31'b0, bus.ex_is_branch}, 32'd0);

    // Asynchronous reset mid-stream
    #3;
    rst_n = 1'b0;
    #1;
    check("arst.valid", {31'b0, bus.ex_valid}, 32'd0);
    check("arst.a", bus.ex_a, 32'd0);
    check("arst.pc", bus.ex_pc, 32'd0);
    check("arst.illegal", {31'b0, bus.ex_illegal}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/id_decode.md
# id_decode

Decode stage for the RV32I core. It accepts fetched instructions over a valid/ready handshake and drives the register-file read addresses. It decodes each instruction into ALU operands, a 4-bit ALU opcode and control flags, and holds them in a single registered output stage that feeds the execute-stage ALU. It also detects load-use hazards against the instruction in its output register and inserts one bubble, and supports a synchronous pipeline flush.

## Interface
Parameters: none; XLEN fixed at 32.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  upstream instruction valid.
- id_ready  out  1  instruction consumed this cycle when id_valid && id_ready.
- id_pc  in  32  PC of the instruction.
- id_instr  in  32  raw instruction word.
- rs1_addr, rs2_addr  out  5  combinational, instr[19:15] and instr[24:20].
- rs1_data, rs2_data  in  32  register-file read data, same cycle.
- flush  in  1  synchronous kill of the output stage.
- ex_valid  out  1  output bundle valid.
- ex_ready  in  1  execute stage accepts the bundle.
- ex_a, ex_b  out  32  ALU operands.
- ex_op  out  4  ALU op: ADD=0, SUB=1, MUL=2, AND=3, OR=4, XOR=5, SHL=6, SHR=7, SLT=8, BEQ=11, BLT=13.
- ex_br_inv  out  1  invert the ALU branch result (BNE, BGE, BGEU).
- ex_pc, ex_imm, ex_rs2_data  out  32  PC, sign-extended immediate, store data.
- ex_rd  out  5  destination register.
- ex_rd_we  out  1  writeback enable; forced 0 when rd=0.
- ex_is_load, ex_is_store, ex_is_branch, ex_is_jal, ex_is_jalr, ex_illegal  out  1 each.

## Operation
- Immediates: I/S/B/U/J formats, sign-extended to 32 bits. Register shift amount is rs2_data[4:0] zero-extended; immediate shift amount is instr[24:20].
- Operand A: rs1_data by default. id_pc for AUIPC, JAL and JALR. 0 for LUI.
- Operand B: rs2_data for R-type and branches. imm for I-type, load, store, LUI and AUIPC. 4 for JAL and JALR, so the ALU produces the link value.
- Op mapping:
  - ADD/ADDI, load, store, LUI, AUIPC, JAL, JALR → ADD. Opcodes 9 and 10 are never emitted.
  - SUB → SUB; MUL (funct7=0000001, funct3=000) → MUL.
  - AND/OR/XOR (+I forms) → AND, OR, XOR; SLL/SLLI → SHL; SRL/SRLI → SRL.
  - SLT/SLTI and SLTU/SLTIU → SLT.
  - BEQ/BNE → BEQ; BLT/BGE/BLTU/BGEU → BLT.
- Signed bias: the ALU compares unsigned. For SLT, SLTI, BLT and BGE, both ex_a and ex_b have bit 31 XORed with 1. Unsigned variants are unbiased.
- Illegal: any of the following sets ex_illegal=1, ex_op=ADD, ex_rd_we=0, and all is_* flags 0. The instruction still issues.
  - Unknown opcode.
  - SRA or SRAI (unsupported).
  - R-type funct7 not in {0000000, 0100000 for SUB only, 0000001 with funct3=000}.
  - Branch funct3 of 010 or 011.
- Writeback: ex_rd_we=1 for R, I, load, LUI, AUIPC, JAL and JALR when rd≠0.
- Load-use hazard, stall = all of:
  - ex_valid && ex_is_load && ex_rd≠0 && id_valid;
  - the incoming instruction reads a matching register: (uses rs1 && rs1_addr==ex_rd) || (uses rs2 && rs2_addr==ex_rd).
  - Only R-type, branch and store use rs2.
- id_ready = (!ex_valid || ex_ready) && !stall && !flush.
- Output register update, priority order:
  1. flush: ex_valid←0.
  2. id_valid && id_ready: load the decoded bundle, ex_valid←1.
  3. ex_ready: ex_valid←0. This covers the bubble case when stall=1.
  4. Otherwise hold all outputs.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is presented with ex_valid=1 after edge N.
- Throughput is 1 instruction per cycle with no hazards.
- A load-use hazard costs exactly 1 bubble cycle.
- While ex_valid && !ex_ready, every ex_* output is stable and id_ready=0.
- Reset (asynchronous, rst_n=0): ex_valid=0 and all ex_* data/flag outputs 0. id_ready is driven combinationally from these, so it is 1 when not stalled and not flushing.
- Reset asserted mid-operation discards the held bundle immediately, without waiting for a clock edge.
- flush and a valid input in the same cycle: the input is not consumed (id_ready=0) and ex_valid=0 next cycle.

## Test plan
- **ADD:** id_instr=0x002081B3 (add x3,x1,x2), rs1_data=5, rs2_data=7 → next cycle ex_valid=1, ex_op=0, ex_a=5, ex_b=7, ex_rd=3, ex_rd_we=1.
- **BGE signed bias:** id_instr=0x0020D463 (bge x1,x2,+8), rs1_data=0xFFFFFFFF, rs2_data=1 → ex_op=13, ex_br_inv=1, ex_a=0x7FFFFFFF, ex_b=0x80000001, ex_imm=8, ex_is_branch=1.
- **Load-use:** lw x5,0(x1) (0x0000A283), then add x6,x5,x1 (0x00128333) with ex_ready=1 → id_ready=0 for one cycle, one ex_valid=0 bubble, then the add issues.
- **Backpressure:** hold ex_ready=0 for 3 cycles with id_valid=1 → ex_* outputs unchanged and id_ready=0 throughout. Release ex_ready → the next instruction appears 1 cycle later.
- **Flush:** assert flush with ex_valid=1 and id_valid=1 → ex_valid=0 next cycle and the input is not consumed.
- **Illegal and reset:** 0x4020D1B3 (sra) → ex_illegal=1, ex_rd_we=0. Pull rst_n low mid-stream → all ex_* outputs are 0 before the next clock edge.
